// File: rtl/trace_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trace_pkg
// Purpose  : Shared types and constants for the retirement-trace monitor:
//            FSM state encoding, halt encodings and trace entry width.
// Revision : 1.0 - initial release
// ============================================================================
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } trace_state_t;

    // jal x0,0 (self-loop) and ecall both mark the end of a program
    localparam logic [31:0] HALT_JAL_SELF = 32'h0000_006F;
    localparam logic [31:0] HALT_ECALL    = 32'h0000_0073;

    localparam int unsigned RD_W = 5;

    // Entry layout, MSB first: {pc, rd, regwrite, wdata}
    function automatic int unsigned entry_width(int unsigned xlen);
        return 2 * xlen + RD_W + 1;
    endfunction

    function automatic logic is_halt_instr(logic [31:0] instr);
        return (instr == HALT_JAL_SELF) || (instr == HALT_ECALL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : trace_monitor_if
// Purpose  : Valid/ready stream carrying one retired-instruction trace entry.
//            master = monitor (producer), slave = consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface trace_monitor_if #(
    parameter int unsigned XLEN = 32
);
    logic            trace_valid;
    logic            trace_ready;
    logic [XLEN-1:0] trace_pc;
    logic [4:0]      trace_rd;
    logic            trace_we;
    logic [XLEN-1:0] trace_wdata;

    modport master (
        output trace_valid, trace_pc, trace_rd, trace_we, trace_wdata,
        input  trace_ready
    );

    modport slave (
        input  trace_valid, trace_pc, trace_rd, trace_we, trace_wdata,
        output trace_ready
    );
endinterface
`default_nettype wire

// File: rtl/trace_monitor_fifo.sv
`default_nettype none
// ============================================================================
// Module   : trace_fifo
// Purpose  : Synchronous FIFO whose head is read straight from registered
//            storage. Pointers carry one extra wrap bit so full and empty are
//            distinguished without wasting an entry. Flush empties it in one
//            cycle.
// Revision : 1.0 - initial release
// ============================================================================
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     flush,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [WIDTH-1:0]         din,
    output logic      [WIDTH-1:0]         head,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // A push into a full FIFO is legal when the head leaves on the same edge:
    // the freed slot is the one being written.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage, pointers and occupancy count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : trace_monitor
// Purpose  : Retirement-trace monitor. Captures retired instructions into a
//            FIFO drained over a valid/ready stream, counts cycles and
//            retirements, and detects program halt or a no-retire timeout.
// Revision : 1.0 - initial release
// ============================================================================
module trace_monitor
    import trace_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   enable,
    input  wire logic                   retire_valid,
    input  wire logic [XLEN-1:0]        retire_pc,
    input  wire logic [31:0]            retire_instr,
    input  wire logic [4:0]             retire_rd,
    input  wire logic                   retire_regwrite,
    input  wire logic [XLEN-1:0]        retire_wdata,
    trace_monitor_if.master             trace,
    output logic [$clog2(DEPTH):0]      fifo_count,
    output logic [1:0]                  state,
    output logic                        overflow,
    output logic [31:0]                 cycle_count,
    output logic [31:0]                 instret
);
    localparam int unsigned ENTRY_W = entry_width(XLEN);
    localparam int unsigned IW      = $clog2(TIMEOUT);

    trace_state_t         cur_state;
    logic [IW-1:0]        idle_cnt;
    logic [ENTRY_W-1:0]   fifo_din;
    logic [ENTRY_W-1:0]   fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 arm;
    logic                 push_req;
    logic                 pop;
    logic                 push_ok;

    // Capture only while running and still enabled; disarming freezes the cycle
    assign arm      = (cur_state == ST_IDLE) && enable;
    assign push_req = (cur_state == ST_RUN) && enable && retire_valid;
    assign pop      = trace.trace_valid && trace.trace_ready;
    assign push_ok  = push_req && (!fifo_full || pop);
    assign fifo_din = {retire_pc, retire_rd, retire_regwrite, retire_wdata};

    assign trace.trace_valid = !fifo_empty;
    assign {trace.trace_pc, trace.trace_rd, trace.trace_we, trace.trace_wdata} = fifo_head;
    assign state = cur_state;

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (arm),
        .push  (push_ok),
        .pop   (pop),
        .din   (fifo_din),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Run-control FSM with its counters, idle watchdog and sticky drop flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state   <= ST_IDLE;
            cycle_count <= '0;
            instret     <= '0;
            overflow    <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            case (cur_state)
                ST_IDLE: begin
                    if (enable) begin
                        cur_state   <= ST_RUN;
                        cycle_count <= '0;
                        instret     <= '0;
                        overflow    <= 1'b0;
                        idle_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        cur_state <= ST_IDLE;
                    end else begin
                        cycle_count <= cycle_count + 32'd1;
                        if (retire_valid) begin
                            // A retirement resets the watchdog, so halt beats timeout
                            instret  <= instret + 32'd1;
                            idle_cnt <= '0;
                            if (!push_ok) begin
                                overflow <= 1'b1;
                            end
                            if (is_halt_instr(retire_instr)) begin
                                cur_state <= ST_HALTED;
                            end
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                            if (idle_cnt == IW'(TIMEOUT - 1)) begin
                                cur_state <= ST_TIMEOUT;
                            end
                        end
                    end
                end
                default: begin
                    if (!enable) begin
                        cur_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_monitor
// Purpose  : Self-checking bench for trace_monitor (DEPTH=4, TIMEOUT=8).
//            A queue-based reference model tracks the expected trace and
//            counters; directed steps cover arming, ordering, overflow,
//            halt and timeout, followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_monitor;
    localparam int XLEN    = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        rv = 1'b0;
    logic [31:0] rpc = '0;
    logic [31:0] rinstr = '0;
    logic [4:0]  rrd = '0;
    logic        rwe = 1'b0;
    logic [31:0] rwd = '0;

    logic [$clog2(DEPTH):0] fifo_count;
    logic [1:0]             state;
    logic                   overflow;
    logic [31:0]            cycle_count;
    logic [31:0]            instret;

    trace_monitor_if #(.XLEN(XLEN)) tif ();

    trace_monitor #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .retire_valid    (rv),
        .retire_pc       (rpc),
        .retire_instr    (rinstr),
        .retire_rd       (rrd),
        .retire_regwrite (rwe),
        .retire_wdata    (rwd),
        .trace           (tif),
        .fifo_count      (fifo_count),
        .state           (state),
        .overflow        (overflow),
        .cycle_count     (cycle_count),
        .instret         (instret)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wdata;
    } entry_t;

    entry_t      q[$];
    int          m_state;
    logic [31:0] m_cycle;
    logic [31:0] m_instret;
    bit          m_ovf;
    int          m_idle;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_state   = 0;
        m_cycle   = 0;
        m_instret = 0;
        m_ovf     = 0;
        m_idle    = 0;
    endtask

    // What one clock edge should do, given the inputs now applied
    task automatic model_edge();
        bit     pop;
        bit     room;
        entry_t e;
        pop  = (q.size() > 0) && tif.trace_ready;
        room = (q.size() < DEPTH) || pop;
        if (pop) void'(q.pop_front());
        if (m_state == 0) begin
            if (enable) begin
                q.delete();
                m_state = 1; m_cycle = 0; m_instret = 0; m_ovf = 0; m_idle = 0;
            end
        end else if (m_state == 1) begin
            if (!enable) begin
                m_state = 0;
            end else begin
                m_cycle = m_cycle + 1;
                if (rv) begin
                    m_instret = m_instret + 1;
                    m_idle = 0;
                    e.pc = rpc; e.rd = rrd; e.we = rwe; e.wdata = rwd;
                    if (room) q.push_back(e);
                    else      m_ovf = 1;
                    if (rinstr == 32'h6F || rinstr == 32'h73) m_state = 2;
                end else begin
                    if (m_idle == TIMEOUT - 1) m_state = 3;
                    m_idle++;
                end
            end
        end else begin
            if (!enable) m_state = 0;
        end
    endtask

    task automatic check_all();
        chk("state", state, m_state);
        chk("fifo_count", fifo_count, q.size());
        chk("trace_valid", tif.trace_valid, q.size() != 0);
        chk("overflow", overflow, m_ovf);
        chk("cycle_count", cycle_count, m_cycle);
        chk("instret", instret, m_instret);
        if (q.size() != 0) begin
            chk("head_pc", tif.trace_pc, q[0].pc);
            chk("head_rd", tif.trace_rd, q[0].rd);
            chk("head_we", tif.trace_we, q[0].we);
            chk("head_wdata", tif.trace_wdata, q[0].wdata);
        end
    endtask

    // Called at a falling edge with inputs already set; returns at the next one
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic retire(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                          input logic [4:0] rd, input bit we, input logic [31:0] wd);
        rv = v; rpc = pc; rinstr = instr; rrd = rd; rwe = we; rwd = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] drain_pc [4];
        int n;
        drain_pc[0] = 32'h104; drain_pc[1] = 32'h108;
        drain_pc[2] = 32'h10C; drain_pc[3] = 32'h110;
        tif.trace_ready = 1'b0;
        model_reset();

        // Reset held for four cycles
        repeat (4) @(posedge clk);
        #1;
        check_all();
        chk("reset_head_pc", tif.trace_pc, 0);
        chk("reset_head_rd", tif.trace_rd, 0);
        chk("reset_head_we", tif.trace_we, 0);
        chk("reset_head_wdata", tif.trace_wdata, 0);
        @(negedge clk);
        rst = 1'b1;

        // Arm
        enable = 1'b1;
        step();
        chk("arm_state", state, 1);

        // Basic trace, consumer always ready
        tif.trace_ready = 1'b1;
        retire(1, 32'h0, 32'h13, 5, 1, 32'h11); step();
        chk("bt_first_pc", tif.trace_pc, 32'h0);
        retire(1, 32'h4, 32'h13, 5, 1, 32'h22); step();
        chk("bt_second_pc", tif.trace_pc, 32'h4);
        retire(1, 32'h8, 32'h13, 5, 1, 32'h33); step();
        chk("bt_third_wdata", tif.trace_wdata, 32'h33);
        retire(0, 0, 0, 0, 0, 0); step();
        chk("bt_instret", instret, 3);

        // Fill to DEPTH, then retire while popping, then overflow
        tif.trace_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            retire(1, 32'h100 + 32'(4 * i), 32'h13, 5'(i), 1, 32'(i)); step();
        end
        chk("full_count", fifo_count, 4);
        chk("full_no_ovf", overflow, 0);
        tif.trace_ready = 1'b1;
        retire(1, 32'h110, 32'h13, 7, 0, 32'hAA); step();
        chk("fullpop_count", fifo_count, 4);
        chk("fullpop_no_ovf", overflow, 0);
        tif.trace_ready = 1'b0;
        retire(1, 32'h114, 32'h13, 8, 1, 32'hBB); step();
        retire(1, 32'h118, 32'h13, 9, 1, 32'hCC); step();
        chk("ovf_count", fifo_count, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_instret", instret, 10);
        retire(0, 0, 0, 0, 0, 0);
        tif.trace_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", tif.trace_pc, drain_pc[i]);
            step();
        end
        chk("drain_empty", tif.trace_valid, 0);

        // Disarm keeps counters, re-arm clears them
        enable = 1'b0; step();
        chk("disarm_state", state, 0);
        enable = 1'b1; step();

        // Halt on jal x0,0
        retire(1, 32'h3C, 32'h13, 1, 1, 32'h5); step();
        retire(1, 32'h40, 32'h6F, 0, 0, 32'h0); step();
        chk("halt_state", state, 2);
        chk("halt_head_pc", tif.trace_pc, 32'h40);
        for (int i = 0; i < 3; i++) begin
            retire(1, 32'h200 + 32'(4 * i), 32'h13, 3, 1, 32'h9); step();
        end
        chk("halt_cycles_frozen", cycle_count, 2);
        chk("halt_instret_frozen", instret, 2);
        retire(0, 0, 0, 0, 0, 0);
        enable = 1'b0; step();
        enable = 1'b1; step();

        // Timeout: one retirement, then silence
        retire(1, 32'h80, 32'h13, 2, 1, 32'h1); step();
        retire(0, 0, 0, 0, 0, 0);
        n = 99;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (state == 2'd3) begin
                n = k;
                break;
            end
        end
        chk("timeout_latency", n, 8);
        enable = 1'b0; step();
        chk("timeout_to_idle", state, 0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            enable = ($urandom % 24) != 0;
            tif.trace_ready = ($urandom % 3) != 0;
            retire(($urandom % 100) < ((i < 300) ? 60 : 6), $urandom,
                   (($urandom % 40) == 0) ? ((($urandom % 2) == 0) ? 32'h6F : 32'h73) : 32'h13,
                   5'($urandom), 1'($urandom), $urandom);
            step();
        end

        // Asynchronous reset in the middle of a run
        enable = 1'b0; retire(0, 0, 0, 0, 0, 0); step();
        enable = 1'b1; step();
        tif.trace_ready = 1'b0;
        retire(1, 32'h300, 32'h13, 4, 1, 32'h77); step();
        retire(1, 32'h304, 32'h13, 4, 1, 32'h78); step();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_head_pc", tif.trace_pc, 0);
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0; retire(0, 0, 0, 0, 0, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/trace_monitor.md
# trace_monitor

Parametrised retirement-trace monitor for the RISC-V core's bench and debug path. It samples each retired instruction (PC, rd, write-back data) into an on-chip FIFO and drains it through a valid/ready port. It also counts cycles and retired instructions, detects program halt (self-loop `jal x0,0` or `ecall`) and flags a no-retire watchdog timeout. It sits beside `TOP` and is wired to its writeback-stage signals, replacing fixed-length open-loop simulation runs.

## Interface
- `XLEN`, 32: data/PC width.
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `TIMEOUT`, 1024: consecutive RUN cycles without a retirement that trigger timeout; ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `enable` in 1: arms the monitor; low returns it to IDLE.
- `retire_valid` in 1: one instruction retires this cycle.
- `retire_pc` in XLEN: PC of the retiring instruction.
- `retire_instr` in 32: encoding of the retiring instruction.
- `retire_rd` in 5: destination register.
- `retire_regwrite` in 1: register write enable.
- `retire_wdata` in XLEN: write-back value.
- `trace_valid` out 1: FIFO head valid.
- `trace_ready` in 1: consumer accepts the head.
- `trace_pc` out XLEN: head PC.
- `trace_rd` out 5: head rd.
- `trace_we` out 1: head regwrite.
- `trace_wdata` out XLEN: head write-back data.
- `fifo_count` out $clog2(DEPTH)+1: occupied entries.
- `state` out 2: IDLE=0, RUN=1, HALTED=2, TIMEOUT=3.
- `overflow` out 1: sticky; at least one retirement was dropped.
- `cycle_count` out 32: RUN cycles since arming.
- `instret` out 32: retirements since arming, including dropped ones.

## Operation
- **Reset** (`rst`=0, asynchronous):
  - state=IDLE.
  - FIFO empty; `trace_valid`=0; `fifo_count`=0.
  - All head fields 0.
  - `overflow`=0; `cycle_count`=0; `instret`=0; idle counter=0.
- **IDLE**:
  - Nothing is captured; counters hold.
  - The FIFO keeps draining.
  - `enable`=1 → RUN next cycle. The same edge clears `cycle_count`, `instret`, `overflow` and the idle counter, and flushes the FIFO.
- **RUN**:
  - `cycle_count` increments every cycle, wrapping modulo 2^32.
  - On `retire_valid`: `instret` increments; the idle counter clears; the entry {pc, rd, regwrite, wdata} is pushed.
  - Push is accepted if count<DEPTH, or if count==DEPTH and a pop happens in the same cycle. Otherwise the entry is dropped and `overflow` is set.
  - Without a retirement the idle counter increments.
- **Halt**:
  - Trigger: `retire_valid` with `retire_instr`==32'h0000006F or 32'h00000073.
  - The halting entry is recorded and counted.
  - Next state is HALTED.
- **Timeout**:
  - Trigger: idle counter reaches TIMEOUT-1 and no retirement occurs in that cycle.
  - Next state is TIMEOUT.
  - If halt and timeout fire in the same cycle, halt wins (a retirement resets the idle counter).
- **HALTED / TIMEOUT**:
  - Capture and counters freeze; the FIFO still drains.
  - `enable`=0 → IDLE.
  - `enable`=0 in RUN → IDLE, with counters and FIFO contents preserved.
- **Pop**: `trace_valid && trace_ready`; the head advances.

## Timing
- Push-to-`trace_valid` latency is 1 cycle: an entry pushed at edge N is visible after edge N.
- With continuous `trace_ready`=1, throughput is 1 entry/cycle.
- `fifo_count` is registered: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Head outputs are stable while `trace_valid`=1 and `trace_ready`=0.
- Full and empty use a pointer MSB-wrap compare; pointers wrap modulo DEPTH without a gap.
- `state`, `overflow` and the counters are registered. The cycle after the halting retirement shows `state`=HALTED.
- Reset asserted mid-run clears everything immediately. Deassertion is synchronised by the integrating top.

## Structure
- `trace_pkg` contains:
  - the state encoding;
  - `HALT_JAL_SELF`=32'h0000006F and `HALT_ECALL`=32'h00000073;
  - the trace entry packing (width XLEN+5+1+XLEN).
- Sub-module `trace_fifo` (params WIDTH, DEPTH): a registered-head synchronous FIFO with count, full and empty. `trace_monitor` holds the FSM, counters and drop logic.

## Test plan
- **Reset/arm**: hold `rst`=0 4 cycles, then `enable`=1 → `state`=RUN one cycle later; all counters 0; `trace_valid`=0.
- **Basic trace**: retire pc 0x0, 0x4, 0x8 (rd=5, wdata=0x11/0x22/0x33) with `trace_ready`=1 → three entries appear in order, each 1 cycle after retirement; `instret`=3.
- **Overflow**: DEPTH=4, `trace_ready`=0, 6 retirements → `fifo_count`=4, `overflow`=1, `instret`=6. Drain → pc values of the first 4 retirements only.
- **Full with simultaneous pop**: count=4, retire and pop in the same cycle → `fifo_count` stays 4; no overflow.
- **Halt**: retire instr 0x0000006F at pc 0x40 → entry recorded; `state`=HALTED next cycle. Further retirements are ignored; `cycle_count` frozen.
- **Timeout**: TIMEOUT=8, one retirement then silence → `state`=TIMEOUT exactly 8 cycles after the retiring cycle. `enable`=0 → IDLE.
